// File: rtl/nanoforge_pipe_adder.sv
// nanoforge_pipe_adder
//   W-bit adder with carry-in. The carry chain is split into STAGES chunks of
//   CH = W/STAGES bits, and each chunk gets its own register stage. Both the
//   input and the output use a valid/ready handshake. Latency is STAGES
//   cycles, and the pipe accepts one beat per cycle while the output drains.
//
// Parameters
//   W       operand/sum width (W % STAGES must be 0)
//   STAGES  pipeline depth = latency in cycles
//
// Build option
//   NANOFORGE_ADDSUB_EN  adds the in_sub port. When in_sub=1 the beat computes
//                        in_a - in_b as in_a + ~in_b + 1 and in_cin is ignored.
//                        out_cout=1 then means no borrow.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   operand beat offered
//   in_ready   out  beat accepted when in_valid & in_ready at a clk edge
//   in_a/in_b  in   W-bit operands
//   in_cin     in   carry-in
//   in_sub     in   subtract select (only with NANOFORGE_ADDSUB_EN)
//   out_valid  out  result beat offered
//   out_ready  in   result consumed when out_valid & out_ready at a clk edge
//   out_sum    out  (in_a + in_b + in_cin) mod 2^W
//   out_cout   out  carry out of bit W-1

// One pipeline stage. It adds chunk K of the travelling operands to the
// incoming carry and replaces that chunk of the partial sum. The operands
// travel with the beat so that later stages can still read their chunks.
module nanoforge_pipe_stage #(
    parameter int W  = 8,
    parameter int CH = 4,
    parameter int K  = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         adv,
    input  logic         prev_valid,
    input  logic [W-1:0] prev_a,
    input  logic [W-1:0] prev_b,
    input  logic [W-1:0] prev_sum,
    input  logic         prev_carry,
    output logic         valid,
    output logic [W-1:0] a,
    output logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         carry
);
    logic [CH:0]  chunk;
    logic [W-1:0] sum_next;

    always_comb begin
        chunk = {1'b0, prev_a[K*CH +: CH]} + {1'b0, prev_b[K*CH +: CH]}
              + {{CH{1'b0}}, prev_carry};
        sum_next = prev_sum;
        sum_next[K*CH +: CH] = chunk[CH-1:0];
    end

    // Data loads only with a valid beat. In the last stage this keeps
    // out_sum/out_cout at the last result while bubbles pass through.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            a     <= '0;
            b     <= '0;
            sum   <= '0;
            carry <= 1'b0;
        end else if (adv) begin
            valid <= prev_valid;
            if (prev_valid) begin
                a     <= prev_a;
                b     <= prev_b;
                sum   <= sum_next;
                carry <= chunk[CH];
            end
        end
    end
endmodule

module nanoforge_pipe_adder #(
    parameter int W      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_cin,
`ifdef NANOFORGE_ADDSUB_EN
    input  logic         in_sub,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_cout
);
    localparam int CH = W / STAGES;

    if ((STAGES < 1) || (W % STAGES != 0)) begin : g_bad_cfg
        $error("nanoforge_pipe_adder: W must be a non-zero multiple of STAGES");
    end

    // Stage outputs. Index k is the register bank of stage k.
    logic [STAGES-1:0]        vld_pipe;
    logic [STAGES-1:0][W-1:0] a_pipe;
    logic [STAGES-1:0][W-1:0] b_pipe;
    logic [STAGES-1:0][W-1:0] sum_pipe;
    logic [STAGES-1:0]        carry_pipe;

    // The beat entering stage 0.
    logic         adv;
    logic         head_valid;
    logic [W-1:0] head_b;
    logic         head_carry;

    // The whole pipe moves as one unit. It stalls only while a finished
    // result waits for the consumer, so in_ready never depends on in_valid.
    assign adv        = ~out_valid | out_ready;
    assign in_ready   = adv;
    assign head_valid = in_valid & adv;

`ifdef NANOFORGE_ADDSUB_EN
    // Two's-complement subtract: invert B and force the carry-in to 1.
    assign head_b     = in_sub ? ~in_b : in_b;
    assign head_carry = in_sub ? 1'b1 : in_cin;
`else
    assign head_b     = in_b;
    assign head_carry = in_cin;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic         p_valid;
        logic [W-1:0] p_a;
        logic [W-1:0] p_b;
        logic [W-1:0] p_sum;
        logic         p_carry;

        if (k == 0) begin : g_head
            assign p_valid = head_valid;
            assign p_a     = in_a;
            assign p_b     = head_b;
            assign p_sum   = '0;
            assign p_carry = head_carry;
        end else begin : g_body
            assign p_valid = vld_pipe[k-1];
            assign p_a     = a_pipe[k-1];
            assign p_b     = b_pipe[k-1];
            assign p_sum   = sum_pipe[k-1];
            assign p_carry = carry_pipe[k-1];
        end

        nanoforge_pipe_stage #(.W(W), .CH(CH), .K(k)) u_stage (
            .clk        (clk),
            .rst        (rst),
            .adv        (adv),
            .prev_valid (p_valid),
            .prev_a     (p_a),
            .prev_b     (p_b),
            .prev_sum   (p_sum),
            .prev_carry (p_carry),
            .valid      (vld_pipe[k]),
            .a          (a_pipe[k]),
            .b          (b_pipe[k]),
            .sum        (sum_pipe[k]),
            .carry      (carry_pipe[k])
        );
    end

    assign out_valid = vld_pipe[STAGES-1];
    assign out_sum   = sum_pipe[STAGES-1];
    assign out_cout  = carry_pipe[STAGES-1];

    // The operands are no longer needed once the last chunk has been added.
    logic unused_tail;
    assign unused_tail = ^{a_pipe[STAGES-1], b_pipe[STAGES-1]};
endmodule

// File: tb/tb_nanoforge_pipe_adder.sv
module tb_nanoforge_pipe_adder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;
    logic       in_cin = 1'b0;
`ifdef NANOFORGE_ADDSUB_EN
    logic       in_sub = 1'b0;
`endif
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_sum;
    logic       out_cout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nanoforge_pipe_adder #(.W(8), .STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef NANOFORGE_ADDSUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
    );

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_a = 8'hAA; in_b = 8'h55; in_cin = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || out_sum !== 8'h00 || out_cout !== 1'b0) begin
                errors++;
                $display("FAIL reset_state: valid=%b sum=%h cout=%b, want 0/00/0", out_valid, out_sum, out_cout);
            end
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        rst = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL reset_no_emit: out_valid=%b want 0 (cycle %0d)", out_valid, i);
            end
        end
    endtask

    task automatic test_carry();
        logic [7:0] va [3] = '{8'hFF, 8'h0F, 8'hFF};
        logic [7:0] vb [3] = '{8'h01, 8'h01, 8'hFF};
        logic       vc [3] = '{1'b0, 1'b1, 1'b1};
        logic [7:0] es [3] = '{8'h00, 8'h11, 8'hFF};
        logic       ec [3] = '{1'b1, 1'b0, 1'b1};
        drain();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = va[i]; in_b = vb[i]; in_cin = vc[i];
            tick();
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL carry_latency_early[%0d]: out_valid=%b want 0", i, out_valid);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_sum !== es[i] || out_cout !== ec[i]) begin
                errors++;
                $display("FAIL carry_result[%0d]: valid=%b sum=%h cout=%b, want 1/%h/%b",
                         i, out_valid, out_sum, out_cout, es[i], ec[i]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] va [16];
        logic [7:0] vb [16];
        logic       vc [16];
        logic [8:0] ex [16];
        int sent = 0, got = 0, first = -1, last = -1;
        logic acc;
        drain();
        for (int i = 0; i < 16; i++) begin
            va[i] = 8'($urandom_range(0, 255));
            vb[i] = 8'($urandom_range(0, 255));
            vc[i] = 1'($urandom_range(0, 1));
            ex[i] = {1'b0, va[i]} + {1'b0, vb[i]} + {8'h00, vc[i]};
        end
        for (int cyc = 0; cyc < 60 && got < 16; cyc++) begin
            if (out_valid === 1'b1) begin
                checks++;
                if ({out_cout, out_sum} !== ex[got]) begin
                    errors++;
                    $display("FAIL b2b_result[%0d]: cout/sum=%h want %h", got, {out_cout, out_sum}, ex[got]);
                end
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            if (sent < 16) begin
                in_valid = 1'b1; in_a = va[sent]; in_b = vb[sent]; in_cin = vc[sent];
            end else begin
                in_valid = 1'b0;
            end
            acc = in_valid & in_ready;
            tick();
            if (acc) sent++;
        end
        in_valid = 1'b0;
        checks++;
        if (got !== 16) begin
            errors++; $display("FAIL b2b_count: got %0d results want 16", got);
        end
        checks++;
        if (last - first !== 15) begin
            errors++; $display("FAIL b2b_rate: results spanned %0d cycles want 15", last - first);
        end
    endtask

    task automatic test_backpressure();
        drain();
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 8'h10; in_b = 8'h20; in_cin = 1'b0;
        tick();
        in_a = 8'h80; in_b = 8'h80; in_cin = 1'b1;
        tick();
        in_a = 8'h33; in_b = 8'h44; in_cin = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== 8'h30 || out_cout !== 1'b0) begin
                errors++;
                $display("FAIL stall[%0d]: rdy=%b valid=%b sum=%h cout=%b, want 0/1/30/0",
                         i, in_ready, out_valid, out_sum, out_cout);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_sum !== 8'h30) begin
            errors++; $display("FAIL release: rdy=%b sum=%h want 1/30", in_ready, out_sum);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 8'h01 || out_cout !== 1'b1) begin
            errors++; $display("FAIL bp_second: valid=%b sum=%h cout=%b want 1/01/1", out_valid, out_sum, out_cout);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 8'h77 || out_cout !== 1'b0) begin
            errors++; $display("FAIL bp_third: valid=%b sum=%h cout=%b want 1/77/0", out_valid, out_sum, out_cout);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_sum !== 8'h77 || out_cout !== 1'b0) begin
            errors++; $display("FAIL bp_no_dup_hold: valid=%b sum=%h cout=%b want 0/77/0", out_valid, out_sum, out_cout);
        end
    endtask

    task automatic test_midreset();
        drain();
        in_valid = 1'b1; in_a = 8'h01; in_b = 8'h01; in_cin = 1'b0;
        tick();
        // The second beat is offered in the reset cycle and must be rejected.
        rst = 1'b1; in_a = 8'h02; in_b = 8'h02;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL midreset_discard[%0d]: out_valid=%b sum=%h want 0", i, out_valid, out_sum);
            end
            tick();
        end
        in_valid = 1'b1; in_a = 8'h03; in_b = 8'h04; in_cin = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 8'h07 || out_cout !== 1'b0) begin
            errors++; $display("FAIL midreset_next: valid=%b sum=%h cout=%b want 1/07/0", out_valid, out_sum, out_cout);
        end
    endtask

`ifdef NANOFORGE_ADDSUB_EN
    task automatic test_addsub();
        drain();
        in_sub = 1'b1;
        in_valid = 1'b1; in_a = 8'h05; in_b = 8'h07; in_cin = 1'b0;
        tick();
        in_a = 8'h07; in_b = 8'h05; in_cin = 1'b1;
        tick();
        in_valid = 1'b0; in_sub = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 8'hFE || out_cout !== 1'b0) begin
            errors++; $display("FAIL sub_borrow: valid=%b sum=%h cout=%b want 1/FE/0", out_valid, out_sum, out_cout);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 8'h02 || out_cout !== 1'b1) begin
            errors++; $display("FAIL sub_noborrow: valid=%b sum=%h cout=%b want 1/02/1", out_valid, out_sum, out_cout);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_carry();
        test_back_to_back();
        test_backpressure();
        test_midreset();
`ifdef NANOFORGE_ADDSUB_EN
        test_addsub();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
